// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI master arbitration core.
//   MSTR_IDX_W : default log2 of master count
//   ID_W       : default per-master ID width
//   rr_next()  : round-robin successor search, current grant scanned last
package axi_arb_pkg;

  localparam int MSTR_IDX_W = 2;
  localparam int ID_W       = 2;
  localparam int RR_MAX_N   = 16;
  localparam int RR_IDX_W   = $clog2(RR_MAX_N);

  // First set bit of req in the order cur+1, cur+2, ..., cur+n (mod n).
  // With no bit set the current index is returned.
  function automatic logic [31:0] rr_next(input logic [RR_MAX_N-1:0] req,
                                          input logic [31:0]         cur,
                                          input logic [31:0]         n);
    logic [31:0] nxt;
    logic [31:0] idx;
    logic        found;
    nxt   = cur;
    found = 1'b0;
    for (int unsigned i = 1; i <= RR_MAX_N; i++) begin
      if (!found && (32'(i) <= n)) begin
        idx = cur + 32'(i);
        if (idx >= n) idx = idx - n;
        if (req[idx[RR_IDX_W-1:0]]) begin
          nxt   = idx;
          found = 1'b1;
        end
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/axi_master_arbiter_if.sv
// Arbiter-facing bundle of the multi-master AXI bus.
//   slave  : arbiter view (bus/master handshakes in, selects and allows out)
//   master : surrounding logic view (drives handshakes, consumes selects)
interface axi_master_arbiter_if #(
  parameter int M_WIDTH = 2,
  parameter int M_ID    = 2
);
  localparam int N   = 2 ** M_WIDTH;
  localparam int IDW = M_ID + M_WIDTH;

  logic [N-1:0]       MASTER_WR_ADDR_VALID;
  logic [N-1:0]       MASTER_RD_ADDR_VALID;
  logic               BUS_WR_ADDR_READY;
  logic               BUS_WR_DATA_VALID;
  logic               BUS_WR_DATA_READY;
  logic               BUS_WR_DATA_LAST;
  logic [IDW-1:0]     BUS_WR_BACK_ID;
  logic               BUS_WR_BACK_VALID;
  logic               BUS_WR_BACK_READY;
  logic [IDW-1:0]     BUS_RD_BACK_ID;
  logic               BUS_RD_DATA_VALID;
  logic               BUS_RD_DATA_READY;
  logic               BUS_RD_DATA_LAST;
  logic               BUS_RD_ADDR_READY;

  logic [M_WIDTH-1:0] wr_addr_sel;
  logic [M_WIDTH-1:0] wr_data_sel;
  logic [M_WIDTH-1:0] wr_resp_sel;
  logic [M_WIDTH-1:0] rd_addr_sel;
  logic [M_WIDTH-1:0] rd_data_sel;
  logic               wr_addr_allow;
  logic               wr_data_allow;
  logic               rd_addr_allow;

  modport slave (
    input  MASTER_WR_ADDR_VALID, MASTER_RD_ADDR_VALID, BUS_WR_ADDR_READY,
           BUS_WR_DATA_VALID, BUS_WR_DATA_READY, BUS_WR_DATA_LAST,
           BUS_WR_BACK_ID, BUS_WR_BACK_VALID, BUS_WR_BACK_READY,
           BUS_RD_BACK_ID, BUS_RD_DATA_VALID, BUS_RD_DATA_READY,
           BUS_RD_DATA_LAST, BUS_RD_ADDR_READY,
    output wr_addr_sel, wr_data_sel, wr_resp_sel, rd_addr_sel, rd_data_sel,
           wr_addr_allow, wr_data_allow, rd_addr_allow
  );

  modport master (
    output MASTER_WR_ADDR_VALID, MASTER_RD_ADDR_VALID, BUS_WR_ADDR_READY,
           BUS_WR_DATA_VALID, BUS_WR_DATA_READY, BUS_WR_DATA_LAST,
           BUS_WR_BACK_ID, BUS_WR_BACK_VALID, BUS_WR_BACK_READY,
           BUS_RD_BACK_ID, BUS_RD_DATA_VALID, BUS_RD_DATA_READY,
           BUS_RD_DATA_LAST, BUS_RD_ADDR_READY,
    input  wr_addr_sel, wr_data_sel, wr_resp_sel, rd_addr_sel, rd_data_sel,
           wr_addr_allow, wr_data_allow, rd_addr_allow
  );

endinterface

// File: rtl/axi_rr_arbiter.sv
// Round-robin address-channel grant register (used for AW and AR).
//   clk, rst : clock, synchronous active-high reset
//   req_i    : per-master VALID
//   hs_i     : handshake on the currently granted master this cycle
//   sel_o    : registered grant
module axi_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter  int SEL_W = 2,
  localparam int N     = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             hs_i,
  output logic [SEL_W-1:0] sel_o
);

  logic [SEL_W-1:0] sel_q, sel_d;

  // A granted master with VALID up and no handshake keeps the grant so its
  // AW/AR payload stays stable. Otherwise move on; the current grant is
  // scanned last, so it only re-wins when nobody else asks.
  always_comb begin
    sel_d = sel_q;
    if (!(req_i[sel_q] && !hs_i) && (|req_i))
      sel_d = SEL_W'(rr_next(RR_MAX_N'(req_i), 32'(sel_q), 32'(N)));
  end

  always_ff @(posedge clk) begin
    if (rst) sel_q <= '0;
    else     sel_q <= sel_d;
  end

  assign sel_o = sel_q;

endmodule

// File: rtl/axi_master_arbiter.sv
// Multi-master AXI arbitration core: produces the five channel selects and
// the three allow gates consumed by the bus switch.
//   clk, rst : clock, synchronous active-high reset
//   bus      : axi_master_arbiter_if.slave -- master AW/AR VALIDs, bus
//              handshakes/IDs in; wr/rd addr/data/resp selects and
//              wr_addr/wr_data/rd_addr allows out
module axi_master_arbiter
  import axi_arb_pkg::*;
#(
  parameter int M_WIDTH        = MSTR_IDX_W,
  parameter int M_ID           = ID_W,
  parameter int WR_OUTSTANDING = 4,
  parameter int RD_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_master_arbiter_if.slave  bus
);

  localparam int D   = WR_OUTSTANDING;
  localparam int PW  = (D > 1) ? $clog2(D) : 1;
  localparam int WCW = $clog2(WR_OUTSTANDING + 1);
  localparam int RCW = $clog2(RD_OUTSTANDING + 1);

  logic [M_WIDTH-1:0] aw_sel, ar_sel;
  logic               aw_hs, ar_hs, w_pop, b_hs, r_hs;
  logic               wr_allow, rd_allow;

  // ---- W order FIFO (index + wrap phase per pointer) ----
  logic [D-1:0][M_WIDTH-1:0] mem_q;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic          wph_q, wph_d, rph_q, rph_d;
  logic          fifo_empty, fifo_full;

  // ---- outstanding counters ----
  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
  logic [RCW-1:0] rd_cnt_q, rd_cnt_d;

  axi_rr_arbiter #(.SEL_W(M_WIDTH)) u_aw_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (bus.MASTER_WR_ADDR_VALID),
    .hs_i  (aw_hs),
    .sel_o (aw_sel)
  );

  axi_rr_arbiter #(.SEL_W(M_WIDTH)) u_ar_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (bus.MASTER_RD_ADDR_VALID),
    .hs_i  (ar_hs),
    .sel_o (ar_sel)
  );

  assign fifo_empty = (wp_q == rp_q) && (wph_q == rph_q);
  assign fifo_full  = (wp_q == rp_q) && (wph_q != rph_q);

  assign wr_allow = (wr_cnt_q < WCW'(WR_OUTSTANDING)) && !fifo_full;
  assign rd_allow = (rd_cnt_q < RCW'(RD_OUTSTANDING));

  assign aw_hs = bus.MASTER_WR_ADDR_VALID[aw_sel] & bus.BUS_WR_ADDR_READY & wr_allow;
  assign ar_hs = bus.MASTER_RD_ADDR_VALID[ar_sel] & bus.BUS_RD_ADDR_READY & rd_allow;
  // An empty FIFO never pops even if the bus misbehaves.
  assign w_pop = bus.BUS_WR_DATA_VALID & bus.BUS_WR_DATA_READY & bus.BUS_WR_DATA_LAST & !fifo_empty;
  assign b_hs  = bus.BUS_WR_BACK_VALID & bus.BUS_WR_BACK_READY;
  assign r_hs  = bus.BUS_RD_DATA_VALID & bus.BUS_RD_DATA_READY & bus.BUS_RD_DATA_LAST;

  always_comb begin
    wp_d  = wp_q;
    wph_d = wph_q;
    rp_d  = rp_q;
    rph_d = rph_q;
    if (aw_hs) begin
      if (wp_q == PW'(D - 1)) begin
        wp_d  = '0;
        wph_d = ~wph_q;
      end else begin
        wp_d  = wp_q + PW'(1);
      end
    end
    if (w_pop) begin
      if (rp_q == PW'(D - 1)) begin
        rp_d  = '0;
        rph_d = ~rph_q;
      end else begin
        rp_d  = rp_q + PW'(1);
      end
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (aw_hs && !b_hs)
      wr_cnt_d = wr_cnt_q + WCW'(1);
    else if (!aw_hs && b_hs && (wr_cnt_q != '0))
      wr_cnt_d = wr_cnt_q - WCW'(1);
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (ar_hs && !r_hs)
      rd_cnt_d = rd_cnt_q + RCW'(1);
    else if (!ar_hs && r_hs && (rd_cnt_q != '0))
      rd_cnt_d = rd_cnt_q - RCW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q     <= '0;
      wph_q    <= 1'b0;
      rp_q     <= '0;
      rph_q    <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wp_q     <= wp_d;
      wph_q    <= wph_d;
      rp_q     <= rp_d;
      rph_q    <= rph_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Storage needs no reset: entries are only read behind a valid pointer.
  always_ff @(posedge clk) begin
    if (aw_hs) mem_q[wp_q] <= aw_sel;
  end

  assign bus.wr_addr_sel   = aw_sel;
  assign bus.rd_addr_sel   = ar_sel;
  assign bus.wr_data_sel   = fifo_empty ? '0 : mem_q[rp_q];
  assign bus.wr_resp_sel   = bus.BUS_WR_BACK_ID[M_ID +: M_WIDTH];
  assign bus.rd_data_sel   = bus.BUS_RD_BACK_ID[M_ID +: M_WIDTH];
  assign bus.wr_addr_allow = wr_allow;
  assign bus.wr_data_allow = !fifo_empty;
  assign bus.rd_addr_allow = rd_allow;

  // Per-master ID bits only matter to the masters themselves.
  logic unused_id_bits;
  assign unused_id_bits = ^{bus.BUS_WR_BACK_ID[M_ID-1:0], bus.BUS_RD_BACK_ID[M_ID-1:0]};

  // A response with nothing outstanding indicates a broken slave/interconnect.
  a_wr_underflow: assert property (@(posedge clk) disable iff (rst) !(b_hs && (wr_cnt_q == '0)));
  a_rd_underflow: assert property (@(posedge clk) disable iff (rst) !(r_hs && (rd_cnt_q == '0)));

endmodule

// File: tb/tb_axi_master_arbiter.sv
module tb_axi_master_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  axi_master_arbiter_if #(.M_WIDTH(2), .M_ID(2)) bus ();

  axi_master_arbiter #(
    .M_WIDTH(2), .M_ID(2), .WR_OUTSTANDING(4), .RD_OUTSTANDING(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wire aw_hs_w = bus.MASTER_WR_ADDR_VALID[bus.wr_addr_sel] & bus.BUS_WR_ADDR_READY & bus.wr_addr_allow;
  wire ar_hs_w = bus.MASTER_RD_ADDR_VALID[bus.rd_addr_sel] & bus.BUS_RD_ADDR_READY & bus.rd_addr_allow;

  task automatic clr_inputs();
    bus.MASTER_WR_ADDR_VALID = '0;
    bus.MASTER_RD_ADDR_VALID = '0;
    bus.BUS_WR_ADDR_READY    = 1'b0;
    bus.BUS_WR_DATA_VALID    = 1'b0;
    bus.BUS_WR_DATA_READY    = 1'b0;
    bus.BUS_WR_DATA_LAST     = 1'b0;
    bus.BUS_WR_BACK_ID       = '0;
    bus.BUS_WR_BACK_VALID    = 1'b0;
    bus.BUS_WR_BACK_READY    = 1'b0;
    bus.BUS_RD_BACK_ID       = '0;
    bus.BUS_RD_DATA_VALID    = 1'b0;
    bus.BUS_RD_DATA_READY    = 1'b0;
    bus.BUS_RD_DATA_LAST     = 1'b0;
    bus.BUS_RD_ADDR_READY    = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Pops exp_q on every AW handshake, bounded by max_cyc negedges.
  task automatic drain_aw(input string nm, input int max_cyc);
    int g = 0;
    int e;
    while (exp_q.size() > 0 && g < max_cyc) begin
      @(negedge clk);
      if (aw_hs_w) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (int'(bus.wr_addr_sel) !== e) begin
          n_err++;
          $display("FAIL %s: wr_addr_sel got %0d want %0d", nm, bus.wr_addr_sel, e);
        end
      end
      g++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: timeout got %0d grants pending want 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (bus.wr_addr_sel !== 2'd0) begin n_err++; $display("FAIL rst_wr_addr_sel got %0d want 0", bus.wr_addr_sel); end
    n_cmp++; if (bus.rd_addr_sel !== 2'd0) begin n_err++; $display("FAIL rst_rd_addr_sel got %0d want 0", bus.rd_addr_sel); end
    n_cmp++; if (bus.wr_data_sel !== 2'd0) begin n_err++; $display("FAIL rst_wr_data_sel got %0d want 0", bus.wr_data_sel); end
    n_cmp++; if (bus.wr_addr_allow !== 1'b1) begin n_err++; $display("FAIL rst_wr_addr_allow got %b want 1", bus.wr_addr_allow); end
    n_cmp++; if (bus.rd_addr_allow !== 1'b1) begin n_err++; $display("FAIL rst_rd_addr_allow got %b want 1", bus.rd_addr_allow); end
    n_cmp++; if (bus.wr_data_allow !== 1'b0) begin n_err++; $display("FAIL rst_wr_data_allow got %b want 0", bus.wr_data_allow); end
  endtask

  // Masters 0,2,3 request; four grants fill wr_cnt and the W FIFO.
  task automatic test_aw_rr();
    do_reset();
    exp_q = '{0, 2, 3, 0};
    bus.MASTER_WR_ADDR_VALID = 4'b1101;
    bus.BUS_WR_ADDR_READY    = 1'b1;
    drain_aw("aw_rr", 10);
    @(posedge clk); #1;
    bus.MASTER_WR_ADDR_VALID = '0;
    bus.BUS_WR_ADDR_READY    = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.wr_addr_allow !== 1'b0) begin n_err++; $display("FAIL aw_full_allow got %b want 0", bus.wr_addr_allow); end
    n_cmp++; if (bus.wr_data_allow !== 1'b1) begin n_err++; $display("FAIL aw_full_wallow got %b want 1", bus.wr_data_allow); end
    n_cmp++; if (bus.wr_data_sel !== 2'd0) begin n_err++; $display("FAIL aw_full_head got %0d want 0", bus.wr_data_sel); end
    // One W burst drains a FIFO slot, but wr_cnt alone still blocks AW.
    @(posedge clk); #1;
    bus.BUS_WR_DATA_VALID = 1'b1; bus.BUS_WR_DATA_READY = 1'b1; bus.BUS_WR_DATA_LAST = 1'b1;
    @(posedge clk); #1;
    bus.BUS_WR_DATA_VALID = 1'b0; bus.BUS_WR_DATA_READY = 1'b0; bus.BUS_WR_DATA_LAST = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.wr_addr_allow !== 1'b0) begin n_err++; $display("FAIL cnt_gate_allow got %b want 0", bus.wr_addr_allow); end
    n_cmp++; if (bus.wr_data_sel !== 2'd2) begin n_err++; $display("FAIL pop_head got %0d want 2", bus.wr_data_sel); end
    // One B response frees a count.
    @(posedge clk); #1;
    bus.BUS_WR_BACK_VALID = 1'b1; bus.BUS_WR_BACK_READY = 1'b1; bus.BUS_WR_BACK_ID = 4'b0000;
    @(posedge clk); #1;
    bus.BUS_WR_BACK_VALID = 1'b0; bus.BUS_WR_BACK_READY = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.wr_addr_allow !== 1'b1) begin n_err++; $display("FAIL b_release_allow got %b want 1", bus.wr_addr_allow); end
  endtask

  // Master 1 granted with READY low must keep the grant despite master 3.
  task automatic test_aw_hold();
    do_reset();
    bus.MASTER_WR_ADDR_VALID = 4'b1010;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      n_cmp++; if (bus.wr_addr_sel !== 2'd1) begin n_err++; $display("FAIL aw_hold got %0d want 1", bus.wr_addr_sel); end
      @(posedge clk);
    end
    #1 bus.BUS_WR_ADDR_READY = 1'b1;
    exp_q = '{1, 3, 1};
    drain_aw("aw_hold_rel", 8);
    @(posedge clk); #1;
    clr_inputs();
  endtask

  // AW from 2 (4 beats) then 1 (2 beats); W owner follows AW order.
  task automatic test_w_order();
    int owner_q[$];
    int len_q[$];
    int beat = 0;
    int g = 0;
    logic last;
    do_reset();
    bus.BUS_WR_ADDR_READY = 1'b1;
    bus.MASTER_WR_ADDR_VALID = 4'b0100; owner_q.push_back(2); len_q.push_back(4);
    exp_q = '{2};
    drain_aw("w_aw2", 6);
    @(posedge clk); #1;
    bus.MASTER_WR_ADDR_VALID = 4'b0010; owner_q.push_back(1); len_q.push_back(2);
    exp_q = '{1};
    drain_aw("w_aw1", 6);
    @(posedge clk); #1;
    bus.MASTER_WR_ADDR_VALID = '0;
    bus.BUS_WR_ADDR_READY    = 1'b0;
    while (owner_q.size() > 0 && g < 20) begin
      last = (beat == len_q[0] - 1);
      bus.BUS_WR_DATA_VALID = 1'b1;
      bus.BUS_WR_DATA_READY = 1'b1;
      bus.BUS_WR_DATA_LAST  = last;
      @(negedge clk);
      if (bus.wr_data_allow) begin
        n_cmp++;
        if (int'(bus.wr_data_sel) !== owner_q[0]) begin
          n_err++;
          $display("FAIL w_owner beat %0d got %0d want %0d", beat, bus.wr_data_sel, owner_q[0]);
        end
        beat++;
        if (last) begin
          void'(owner_q.pop_front());
          void'(len_q.pop_front());
          beat = 0;
        end
      end
      @(posedge clk); #1;
      g++;
    end
    if (owner_q.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL w_order timeout got %0d bursts pending want 0", owner_q.size());
    end
    bus.BUS_WR_DATA_VALID = 1'b0; bus.BUS_WR_DATA_READY = 1'b0; bus.BUS_WR_DATA_LAST = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.wr_data_allow !== 1'b0) begin n_err++; $display("FAIL w_empty_allow got %b want 0", bus.wr_data_allow); end
    n_cmp++; if (bus.wr_data_sel !== 2'd0) begin n_err++; $display("FAIL w_empty_sel got %0d want 0", bus.wr_data_sel); end
  endtask

  // Read outstanding limit, and R-last + AR in the same cycle.
  task automatic test_rd_cnt();
    int g = 0;
    int e;
    do_reset();
    bus.MASTER_RD_ADDR_VALID = 4'b0001;
    bus.BUS_RD_ADDR_READY    = 1'b1;
    exp_q = '{0, 0, 0, 0};
    while (exp_q.size() > 0 && g < 10) begin
      @(negedge clk);
      if (ar_hs_w) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (int'(bus.rd_addr_sel) !== e) begin n_err++; $display("FAIL ar_grant got %0d want %0d", bus.rd_addr_sel, e); end
      end
      g++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL ar_grant timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    n_cmp++; if (bus.rd_addr_allow !== 1'b0) begin n_err++; $display("FAIL rd_full_allow got %b want 0", bus.rd_addr_allow); end
    @(posedge clk); #1;
    bus.MASTER_RD_ADDR_VALID = '0;
    bus.BUS_RD_DATA_VALID = 1'b1; bus.BUS_RD_DATA_READY = 1'b1; bus.BUS_RD_DATA_LAST = 1'b1;
    @(posedge clk); #1;
    bus.MASTER_RD_ADDR_VALID = 4'b0001;
    @(negedge clk);
    n_cmp++; if (bus.rd_addr_allow !== 1'b1) begin n_err++; $display("FAIL rd_after_r_allow got %b want 1", bus.rd_addr_allow); end
    @(posedge clk); #1;
    bus.BUS_RD_DATA_VALID = 1'b0; bus.BUS_RD_DATA_READY = 1'b0; bus.BUS_RD_DATA_LAST = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.rd_addr_allow !== 1'b1) begin n_err++; $display("FAIL rd_both_allow got %b want 1", bus.rd_addr_allow); end
    @(posedge clk); #1;
    bus.MASTER_RD_ADDR_VALID = '0;
    @(negedge clk);
    n_cmp++; if (bus.rd_addr_allow !== 1'b0) begin n_err++; $display("FAIL rd_refill_allow got %b want 0", bus.rd_addr_allow); end
  endtask

  // Response selects come straight from the top ID bits (READY held low).
  task automatic test_resp_sel();
    logic [3:0] ids [4];
    logic [1:0] exp [4];
    ids = '{4'b1101, 4'b0011, 4'b0110, 4'b1000};
    exp = '{2'd3,    2'd0,    2'd1,    2'd2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.BUS_WR_BACK_VALID = 1'b1; bus.BUS_WR_BACK_ID = ids[i];
      bus.BUS_RD_DATA_VALID = 1'b1; bus.BUS_RD_BACK_ID = ids[3 - i];
      @(negedge clk);
      n_cmp++; if (bus.wr_resp_sel !== exp[i]) begin n_err++; $display("FAIL wr_resp_sel id %b got %0d want %0d", ids[i], bus.wr_resp_sel, exp[i]); end
      n_cmp++; if (bus.rd_data_sel !== exp[3 - i]) begin n_err++; $display("FAIL rd_data_sel id %b got %0d want %0d", ids[3 - i], bus.rd_data_sel, exp[3 - i]); end
      @(posedge clk); #1;
    end
    clr_inputs();
  endtask

  initial begin
    clr_inputs();
    test_reset();
    test_aw_rr();
    test_aw_hold();
    test_w_order();
    test_rd_cnt();
    test_resp_sel();
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
